// File: rtl/reset_sequencer_if.sv
// Interface bundling the software request and the sequenced reset outputs
// of reset_sequencer. The slave modport is the sequencer itself; the master
// modport is whatever drives sw_req_i and observes the per-domain resets.
interface reset_sequencer_if #(
    parameter int N_DOMAIN = 4
);
    logic                sw_req_i;
    logic [N_DOMAIN-1:0] rst_n_o;
    logic                done_o;

    modport master (
        output sw_req_i,
        input  rst_n_o,
        input  done_o
    );

    modport slave (
        input  sw_req_i,
        output rst_n_o,
        output done_o
    );
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer: synchronises the board reset rst_i into the clk domain and
// releases N_DOMAIN active-low reset outputs in order (bit 0 first), with a
// hold time after synchronisation and a gap between domains. A software
// request re-runs the sequence without touching rst_i.
// Optional build macro RESET_SEQ_ORDERED_ASSERT_EN: a software request taken
// in RUN asserts the domains in reverse order, one per gap, before re-holding.
module reset_sequencer #(
    parameter int SYNC_STAGE  = 3,
    parameter int N_DOMAIN    = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4
) (
    input  logic               clk,
    input  logic               rst_i,
    reset_sequencer_if.slave   bus
);
    localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam int IW      = (N_DOMAIN > 1) ? $clog2(N_DOMAIN) : 1;
    // The SYNC->HOLD transition of the state register acts as the final
    // synchroniser stage, so the explicit chain is one flop shorter.
    localparam int CHAIN   = SYNC_STAGE - 1;

    localparam logic [CW-1:0]       CNT_SAT   = '1;
    localparam logic [CW-1:0]       HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]       GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0]       LAST_IDX  = IW'(N_DOMAIN - 1);
    localparam logic [N_DOMAIN-1:0] ONE       = N_DOMAIN'(1);

`ifdef RESET_SEQ_ORDERED_ASSERT_EN
    typedef enum logic [2:0] {ST_SYNC, ST_HOLD, ST_RELEASE, ST_RUN, ST_ASSERT} state_t;
`else
    typedef enum logic [1:0] {ST_SYNC, ST_HOLD, ST_RELEASE, ST_RUN} state_t;
`endif

    state_t              state_q, state_d;
    logic [CHAIN-1:0]    sync_q;
    logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [IW-1:0]       idx_q, idx_d, nxt_idx;
    logic [N_DOMAIN-1:0] rst_n_q, rst_n_d;
    logic                done_q, done_d;
`ifdef RESET_SEQ_ORDERED_ASSERT_EN
    logic [IW-1:0]       prv_idx;
`endif

    // Shift 1s into the synchroniser chain; cleared asynchronously by rst_i.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) sync_q <= '0;
        else        sync_q <= (sync_q << 1) | CHAIN'(1);
    end

    // Register FSM state, counters and the (registered) outputs.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_SYNC;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_n_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_n_q <= rst_n_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: hold, release one domain per gap, restart on request.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_n_d = rst_n_q;
        done_d  = done_q;
        nxt_idx = idx_q + 1'b1;
`ifdef RESET_SEQ_ORDERED_ASSERT_EN
        prv_idx = idx_q - 1'b1;
`endif
        cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

        case (state_q)
            ST_SYNC: begin
                rst_n_d = '0;
                done_d  = 1'b0;
                if (sync_q[CHAIN-1]) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                if (bus.sw_req_i) begin
                    cnt_d   = '0;
                    rst_n_d = '0;
                    done_d  = 1'b0;
                end else if (cnt_q == HOLD_LAST) begin
                    rst_n_d = rst_n_q | ONE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    if (N_DOMAIN == 1) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RELEASE: begin
                if (bus.sw_req_i) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    rst_n_d = '0;
                    done_d  = 1'b0;
                end else if (cnt_q == GAP_LAST) begin
                    rst_n_d = rst_n_q | (ONE << nxt_idx);
                    idx_d   = nxt_idx;
                    cnt_d   = '0;
                    if (nxt_idx == LAST_IDX) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RUN: begin
                if (bus.sw_req_i) begin
                    cnt_d  = '0;
                    done_d = 1'b0;
`ifdef RESET_SEQ_ORDERED_ASSERT_EN
                    rst_n_d = rst_n_q & ~(ONE << LAST_IDX);
                    idx_d   = LAST_IDX;
                    state_d = (N_DOMAIN == 1) ? ST_HOLD : ST_ASSERT;
`else
                    rst_n_d = '0;
                    state_d = ST_HOLD;
`endif
                end
            end
`ifdef RESET_SEQ_ORDERED_ASSERT_EN
            ST_ASSERT: begin
                if (cnt_q == GAP_LAST) begin
                    rst_n_d = rst_n_q & ~(ONE << prv_idx);
                    idx_d   = prv_idx;
                    cnt_d   = '0;
                    if (idx_q == IW'(1)) state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
`endif
            default: begin
                state_d = ST_SYNC;
                cnt_d   = '0;
                rst_n_d = '0;
                done_d  = 1'b0;
            end
        endcase
    end

    assign bus.rst_n_o = rst_n_q;
    assign bus.done_o  = done_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Directed testbench for reset_sequencer: power-up ordering, asynchronous
// reset pulse, software requests (single and held, ignored in SYNC) and a
// single-domain corner instance. Honours RESET_SEQ_ORDERED_ASSERT_EN.
module tb_reset_sequencer;
    logic clk = 1'b0;
    logic rst_i;
    int   checks = 0;
    int   errors = 0;

    reset_sequencer_if #(.N_DOMAIN(4)) bus ();
    reset_sequencer_if #(.N_DOMAIN(1)) cbus ();

    reset_sequencer #(
        .SYNC_STAGE(3), .N_DOMAIN(4), .HOLD_CYCLES(16), .GAP_CYCLES(4)
    ) dut (
        .clk(clk), .rst_i(rst_i), .bus(bus)
    );

    reset_sequencer #(
        .SYNC_STAGE(2), .N_DOMAIN(1), .HOLD_CYCLES(1), .GAP_CYCLES(4)
    ) dut_corner (
        .clk(clk), .rst_i(rst_i), .bus(cbus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Expected release mask: bit k is released once edge e reaches base + 4k.
    function automatic logic [3:0] relMask(input int e, input int base);
        logic [3:0] m = 4'b0000;
        for (int k = 0; k < 4; k++) if (e >= base + k * 4) m[k] = 1'b1;
        return m;
    endfunction

    task automatic applyStimulus(input logic rst, input logic req);
        rst_i        = rst;
        bus.sw_req_i = req;
    endtask

    task automatic waitEdge();
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] expRst, input logic expDone);
        checks++;
        assert (bus.rst_n_o === expRst) else begin
            errors++;
            $error("[TB] FAIL %s rst_n_o got %b expected %b", tag, bus.rst_n_o, expRst);
        end
        checks++;
        assert (bus.done_o === expDone) else begin
            errors++;
            $error("[TB] FAIL %s done_o got %b expected %b", tag, bus.done_o, expDone);
        end
    endtask

    task automatic checkCorner(input string tag, input logic expOut);
        checks++;
        assert (cbus.rst_n_o === expOut && cbus.done_o === expOut) else begin
            errors++;
            $error("[TB] FAIL %s corner rst_n_o/done_o got %b/%b expected %b",
                   tag, cbus.rst_n_o, cbus.done_o, expOut);
        end
    endtask

    // Safety net: the run is bounded by its own loops, this only catches hangs.
    initial begin
        #100000;
        $display("[TB] FAIL timeout CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        cbus.sw_req_i = 1'b0;
        applyStimulus(1'b0, 1'b0);
        #1;
        checkOutput("reset_t0", 4'b0000, 1'b0);
        checkCorner("reset_t0", 1'b0);
        for (int i = 0; i < 5; i++) begin
            waitEdge();
            checkOutput($sformatf("reset_hold_%0d", i), 4'b0000, 1'b0);
        end

        // Power-up, interrupted by an asynchronous pulse after edge 25.
        applyStimulus(1'b1, 1'b0);
        for (int e = 1; e <= 25; e++) begin
            waitEdge();
            checkOutput($sformatf("pwr1_e%0d", e), relMask(e, 19), e >= 31);
            if (e <= 5) checkCorner($sformatf("pwr1_e%0d", e), e >= 3);
        end
        applyStimulus(1'b0, 1'b0);
        #1;
        checkOutput("async_pulse", 4'b0000, 1'b0);
        checkCorner("async_pulse", 1'b0);
        waitEdge();
        waitEdge();
        checkOutput("async_held", 4'b0000, 1'b0);

        // Full re-run of the sequence after re-release.
        applyStimulus(1'b1, 1'b0);
        for (int e = 1; e <= 35; e++) begin
            waitEdge();
            checkOutput($sformatf("pwr2_e%0d", e), relMask(e, 19), e >= 31);
            if (e <= 4) checkCorner($sformatf("pwr2_e%0d", e), e >= 3);
        end

        // Single-cycle software request in RUN at edge E (r = edges after E).
        applyStimulus(1'b1, 1'b1);
        waitEdge();
        applyStimulus(1'b1, 1'b0);
`ifdef RESET_SEQ_ORDERED_ASSERT_EN
        for (int r = 0; r <= 42; r++) begin
            logic [3:0] m;
            if (r > 0) waitEdge();
            if (r <= 12) begin
                m = 4'b0000;
                for (int k = 0; k < 3 - r / 4; k++) m[k] = 1'b1;
            end else begin
                m = relMask(r, 28);
            end
            checkOutput($sformatf("swreq_r%0d", r), m, r >= 40);
        end
`else
        for (int r = 0; r <= 30; r++) begin
            if (r > 0) waitEdge();
            checkOutput($sformatf("swreq_r%0d", r), relMask(r, 16), r >= 28);
        end
`endif
        checkCorner("corner_unaffected", 1'b1);

        // Reset again; sw_req high during SYNC (edges 1..3) must be ignored.
        applyStimulus(1'b0, 1'b0);
        #1;
        checkOutput("async_pulse2", 4'b0000, 1'b0);
        waitEdge();
        applyStimulus(1'b1, 1'b1);
        for (int e = 1; e <= 23; e++) begin
            waitEdge();
            if (e == 3) applyStimulus(1'b1, 1'b0);
            checkOutput($sformatf("pwr3_e%0d", e), relMask(e, 19), 1'b0);
        end

        // Held request for 10 edges starting with rst_n_o = 0011 (RELEASE).
        applyStimulus(1'b1, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            waitEdge();
            checkOutput($sformatf("held_%0d", i), 4'b0000, 1'b0);
        end
        applyStimulus(1'b1, 1'b0);
        for (int r = 1; r <= 30; r++) begin
            waitEdge();
            checkOutput($sformatf("after_held_r%0d", r), relMask(r, 16), r >= 28);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
